// File: rtl/spi_slave_ctrl.sv
// SPI slave engine for the configuration register bank: oversampled pins, 16-bit instruction
// decode, per-byte address/write/read sequencing. Optional macro SPI_ADDR_ASCEND_EN makes the address step ascend.
module spi_slave_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 13
) (
    input  logic              I_clk,
    input  logic              I_reset_n,
    input  logic              I_sclk,
    input  logic              I_csb,
    input  logic              I_sdi,
    input  logic [7:0]        I_reg_rdata,
    output logic              O_sdo,
    output logic              O_sdo_oe,
    output logic [ADDR_W-1:0] O_reg_addr,
    output logic [7:0]        O_reg_wdata,
    output logic              O_reg_wen,
    output logic              O_reg_rd,
    output logic              O_busy
);

    // state | meaning
    // IDLE  | waiting for a synchronized CSB falling edge
    // INSTR | shifting the 16-bit instruction word
    // DATA  | per-byte write assembly or read-data shifting
    // DONE  | counted bytes finished; wait for CSB high
    typedef enum logic [1:0] {ST_IDLE, ST_INSTR, ST_DATA, ST_DONE} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, csb_sync_q, sdi_sync_q;
    logic                   sclk_hist_q, csb_hist_q;
    logic                   sclk_s, csb_s, sdi_s;
    logic                   sclk_rise, sclk_fall, csb_fall;
    logic [15:0]            instr_word;
    logic [ADDR_W-1:0]      addr_step;

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [14:0]       shift_q, shift_d;
    logic              rw_q, rw_d;
    logic [1:0]        w_q, w_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              rd_q, rd_d;
    logic [7:0]        rsh_q, rsh_d;
    logic              sdo_q, sdo_d;
    logic              sdo_oe_q, sdo_oe_d;
    logic              busy_q, busy_d;
    logic              step_q, step_d;
    logic [1:0]        rd_dly_q, rd_dly_d;

    // CSB chain resets low so a CSB already low at reset release never looks like a falling edge.
    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            sclk_sync_q <= '0;
            csb_sync_q  <= '0;
            sdi_sync_q  <= '0;
            sclk_hist_q <= 1'b0;
            csb_hist_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], I_sclk};
            csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], I_csb};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], I_sdi};
            sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
            csb_hist_q  <= csb_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign csb_s      = csb_sync_q[SYNC_STAGES-1];
    assign sdi_s      = sdi_sync_q[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_hist_q;
    assign sclk_fall  = ~sclk_s & sclk_hist_q;
    assign csb_fall   = ~csb_s & csb_hist_q;
    assign instr_word = {shift_q, sdi_s};

`ifdef SPI_ADDR_ASCEND_EN
    assign addr_step = addr_q + ADDR_W'(1);
`else
    assign addr_step = addr_q - ADDR_W'(1);
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        w_d        = w_q;
        addr_d     = step_q ? addr_step : addr_q;
        wdata_d    = wdata_q;
        wen_d      = 1'b0;
        rd_d       = 1'b0;
        rsh_d      = rsh_q;
        sdo_d      = sdo_q;
        sdo_oe_d   = sdo_oe_q;
        step_d     = 1'b0;
        rd_dly_d   = {rd_dly_q[0], step_q & rw_q & (state_q == ST_DATA)};

        unique case (state_q)
            ST_IDLE: begin
                if (csb_fall) begin
                    state_d    = ST_INSTR;
                    bit_cnt_d  = 4'd0;
                    byte_cnt_d = 2'd0;
                end
            end
            ST_INSTR: begin
                if (sclk_rise) begin
                    shift_d   = instr_word[14:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        rw_d        = instr_word[15];
                        w_d         = instr_word[14:13];
                        addr_d      = instr_word[ADDR_W-1:0];
                        rd_dly_d[0] = instr_word[15];
                        bit_cnt_d   = 4'd0;
                        state_d     = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (sclk_rise) begin
                    shift_d   = instr_word[14:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d  = 4'd0;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        step_d     = 1'b1;
                        if (!rw_q) begin
                            wen_d   = 1'b1;
                            wdata_d = instr_word[7:0];
                        end
                        if ((w_q != 2'b11) && (byte_cnt_q == w_q))
                            state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase

        // SDO advances on falls; the first fall once DONE is reached releases the pin.
        if (sclk_fall && sdo_oe_q) begin
            if (state_q == ST_DONE) begin
                sdo_oe_d = 1'b0;
                sdo_d    = 1'b0;
            end else begin
                sdo_d = rsh_q[7];
                rsh_d = {rsh_q[6:0], 1'b0};
            end
        end

        if (rd_dly_q[1] && (state_q == ST_DATA) && !csb_s) begin
            rd_d     = 1'b1;
            rsh_d    = I_reg_rdata;
            sdo_oe_d = 1'b1;
        end

        // A write completing in the same cycle CSB is seen high still strobes.
        if (csb_s) begin
            state_d  = ST_IDLE;
            sdo_oe_d = 1'b0;
            sdo_d    = 1'b0;
            rd_d     = 1'b0;
            rd_dly_d = 2'b00;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            w_q        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            rd_q       <= 1'b0;
            rsh_q      <= '0;
            sdo_q      <= 1'b0;
            sdo_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            step_q     <= 1'b0;
            rd_dly_q   <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            w_q        <= w_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wen_q      <= wen_d;
            rd_q       <= rd_d;
            rsh_q      <= rsh_d;
            sdo_q      <= sdo_d;
            sdo_oe_q   <= sdo_oe_d;
            busy_q     <= busy_d;
            step_q     <= step_d;
            rd_dly_q   <= rd_dly_d;
        end
    end

    assign O_sdo       = sdo_q;
    assign O_sdo_oe    = sdo_oe_q;
    assign O_reg_addr  = addr_q;
    assign O_reg_wdata = wdata_q;
    assign O_reg_wen   = wen_q;
    assign O_reg_rd    = rd_q;
    assign O_busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: writes, reads, streaming wrap, CSB abort and mid-transfer reset.
module tb_spi_slave_ctrl;

    logic        I_clk = 1'b0;
    logic        I_reset_n;
    logic        I_sclk, I_csb, I_sdi;
    logic [7:0]  I_reg_rdata;
    logic        O_sdo, O_sdo_oe, O_reg_wen, O_reg_rd, O_busy;
    logic [12:0] O_reg_addr;
    logic [7:0]  O_reg_wdata;

    int checks   = 0;
    int failures = 0;

    int          wen_n, rd_n, both_n, wen_long_n;
    logic [12:0] wen_addr [8];
    logic [7:0]  wen_data [8];
    logic [12:0] rd_addr;
    logic        oe_seen, wen_prev;

    spi_slave_ctrl dut (
        .I_clk(I_clk), .I_reset_n(I_reset_n), .I_sclk(I_sclk), .I_csb(I_csb), .I_sdi(I_sdi),
        .I_reg_rdata(I_reg_rdata), .O_sdo(O_sdo), .O_sdo_oe(O_sdo_oe), .O_reg_addr(O_reg_addr),
        .O_reg_wdata(O_reg_wdata), .O_reg_wen(O_reg_wen), .O_reg_rd(O_reg_rd), .O_busy(O_busy)
    );

    always #5 I_clk = ~I_clk;

    always @(negedge I_clk) begin
        if (O_reg_wen) begin
            if (wen_n < 8) begin
                wen_addr[wen_n] = O_reg_addr;
                wen_data[wen_n] = O_reg_wdata;
            end
            wen_n++;
            if (wen_prev) wen_long_n++;
        end
        if (O_reg_rd) begin
            rd_addr = O_reg_addr;
            rd_n++;
        end
        if (O_reg_wen && O_reg_rd) both_n++;
        if (O_sdo_oe) oe_seen = 1'b1;
        wen_prev = O_reg_wen;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge I_clk);
    endtask

    task automatic clear_mon();
        wen_n = 0; rd_n = 0; oe_seen = 1'b0;
    endtask

    task automatic spi_bit(input logic b, output logic s);
        I_sdi = b;
        clks(4);
        s = O_sdo;
        I_sclk = 1'b1;
        clks(8);
        I_sclk = 1'b0;
        clks(4);
    endtask

    task automatic spi_byte(input logic [7:0] v, output logic [7:0] s);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(v[i], r);
            s[i] = r;
        end
    endtask

    task automatic spi_word(input logic [15:0] v);
        logic [7:0] d;
        spi_byte(v[15:8], d);
        spi_byte(v[7:0], d);
    endtask

    task automatic spi_start();
        I_csb = 1'b0;
        clks(8);
    endtask

    task automatic spi_end();
        clks(4);
        I_csb = 1'b1;
        clks(8);
    endtask

    task automatic test_reset();
        I_reset_n = 1'b0; I_sclk = 1'b0; I_csb = 1'b1; I_sdi = 1'b0; I_reg_rdata = 8'h3C;
        wen_n = 0; rd_n = 0; both_n = 0; wen_long_n = 0; oe_seen = 1'b0; wen_prev = 1'b0;
        clks(4);
        checks++;
        if ({O_sdo, O_sdo_oe, O_reg_wen, O_reg_rd, O_busy, O_reg_wdata} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {O_sdo, O_sdo_oe, O_reg_wen, O_reg_rd, O_busy, O_reg_wdata});
        end
        checks++;
        if (O_reg_addr !== 13'h0) begin
            failures++; $display("FAIL reset_addr got=%h exp=0000", O_reg_addr);
        end
        I_reset_n = 1'b1;
        clks(6);
    endtask

    task automatic test_write1();
        logic [7:0] d;
        clear_mon();
        spi_start();
        checks++;
        if (O_busy !== 1'b1) begin failures++; $display("FAIL w1_busy_on got=%b exp=1", O_busy); end
        spi_word(16'h0014);
        spi_byte(8'hA5, d);
        spi_end();
        checks++;
        if (wen_n !== 1) begin failures++; $display("FAIL w1_count got=%0d exp=1", wen_n); end
        checks++;
        if (wen_addr[0] !== 13'h014 || wen_data[0] !== 8'hA5) begin
            failures++; $display("FAIL w1_addr_data got=%h/%h exp=0014/a5", wen_addr[0], wen_data[0]);
        end
        checks++;
        if (oe_seen !== 1'b0) begin failures++; $display("FAIL w1_sdo_oe got=%b exp=0", oe_seen); end
        checks++;
        if (O_busy !== 1'b0) begin failures++; $display("FAIL w1_busy_off got=%b exp=0", O_busy); end
    endtask

    task automatic test_read1();
        logic [7:0] got;
        clear_mon();
        I_reg_rdata = 8'h3C;
        spi_start();
        spi_word(16'h8001);
        spi_byte(8'h00, got);
        clks(2);
        checks++;
        if (rd_n !== 1 || rd_addr !== 13'h001) begin
            failures++; $display("FAIL r1_rd got=%0d@%h exp=1@0001", rd_n, rd_addr);
        end
        checks++;
        if (got !== 8'h3C) begin failures++; $display("FAIL r1_sdo_bits got=%h exp=3c", got); end
        checks++;
        if (O_sdo_oe !== 1'b0 || oe_seen !== 1'b1) begin
            failures++; $display("FAIL r1_sdo_oe got=%b seen=%b exp=0 seen=1", O_sdo_oe, oe_seen);
        end
        checks++;
        if (wen_n !== 0) begin failures++; $display("FAIL r1_no_wen got=%0d exp=0", wen_n); end
        spi_end();
        checks++;
        if (O_busy !== 1'b0) begin failures++; $display("FAIL r1_busy_off got=%b exp=0", O_busy); end
    endtask

    task automatic test_write3();
        logic [7:0]  d;
        logic [12:0] ea [3];
        logic [7:0]  ed [3];
        ea[0] = 13'h0FF; ea[1] = 13'h0FE; ea[2] = 13'h0FD;
        ed[0] = 8'h11;   ed[1] = 8'h22;   ed[2] = 8'h33;
        clear_mon();
        spi_start();
        spi_word(16'h40FF);
        for (int i = 0; i < 3; i++) spi_byte(ed[i], d);
        spi_byte(8'h44, d);
        spi_end();
        checks++;
        if (wen_n !== 3) begin failures++; $display("FAIL w3_count got=%0d exp=3", wen_n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wen_addr[i] !== ea[i] || wen_data[i] !== ed[i]) begin
                failures++;
                $display("FAIL w3_byte%0d got=%h/%h exp=%h/%h", i, wen_addr[i], wen_data[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_stream();
        logic [7:0]  d;
        logic [15:0] instr;
        logic [12:0] ea [4];
        logic [7:0]  ed [4];
`ifdef SPI_ADDR_ASCEND_EN
        instr = 16'h7FFE;
        ea[0] = 13'h1FFE; ea[1] = 13'h1FFF; ea[2] = 13'h0000; ea[3] = 13'h0001;
`else
        instr = 16'h6001;
        ea[0] = 13'h0001; ea[1] = 13'h0000; ea[2] = 13'h1FFF; ea[3] = 13'h1FFE;
`endif
        ed[0] = 8'hAA; ed[1] = 8'hBB; ed[2] = 8'hCC; ed[3] = 8'hDD;
        clear_mon();
        spi_start();
        spi_word(instr);
        for (int i = 0; i < 4; i++) spi_byte(ed[i], d);
        spi_end();
        checks++;
        if (wen_n !== 4) begin failures++; $display("FAIL stream_count got=%0d exp=4", wen_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wen_addr[i] !== ea[i] || wen_data[i] !== ed[i]) begin
                failures++;
                $display("FAIL stream_byte%0d got=%h/%h exp=%h/%h", i, wen_addr[i], wen_data[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_csb_abort();
        logic       r;
        logic [7:0] d;
        clear_mon();
        spi_start();
        spi_word(16'h0030);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, r);
        spi_end();
        checks++;
        if (wen_n !== 0) begin failures++; $display("FAIL abort_no_wen got=%0d exp=0", wen_n); end
        checks++;
        if (O_busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", O_busy); end
        spi_start();
        spi_word(16'h0020);
        spi_byte(8'h5A, d);
        spi_end();
        checks++;
        if (wen_n !== 1 || wen_addr[0] !== 13'h020 || wen_data[0] !== 8'h5A) begin
            failures++;
            $display("FAIL abort_next got=%0d %h/%h exp=1 0020/5a", wen_n, wen_addr[0], wen_data[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic       r;
        logic [7:0] d;
        logic [15:0] v;
        v = 16'h0040;
        clear_mon();
        spi_start();
        for (int i = 15; i >= 6; i--) spi_bit(v[i], r);
        checks++;
        if (O_busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", O_busy); end
        I_reset_n = 1'b0;
        #1;
        checks++;
        if (O_busy !== 1'b0 || O_reg_addr !== 13'h0) begin
            failures++; $display("FAIL rstmid_immediate got=%b/%h exp=0/0000", O_busy, O_reg_addr);
        end
        clks(3);
        I_reset_n = 1'b1;
        clks(2);
        for (int i = 5; i >= 0; i--) spi_bit(v[i], r);
        spi_byte(8'h99, d);
        checks++;
        if (wen_n !== 0 || O_busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_ignored got=%0d/%b exp=0/0", wen_n, O_busy);
        end
        spi_end();
        spi_start();
        spi_word(16'h0045);
        spi_byte(8'h77, d);
        spi_end();
        checks++;
        if (wen_n !== 1 || wen_addr[0] !== 13'h045 || wen_data[0] !== 8'h77) begin
            failures++;
            $display("FAIL rstmid_after got=%0d %h/%h exp=1 0045/77", wen_n, wen_addr[0], wen_data[0]);
        end
    endtask

    task automatic test_strobes();
        checks++;
        if (both_n !== 0) begin failures++; $display("FAIL wen_rd_overlap got=%0d exp=0", both_n); end
        checks++;
        if (wen_long_n !== 0) begin failures++; $display("FAIL wen_width got=%0d exp=0", wen_long_n); end
    endtask

    initial begin
        test_reset();
        test_write1();
        test_read1();
        test_write3();
        test_stream();
        test_csb_abort();
        test_reset_mid();
        test_strobes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
